sensor_poll_rx: RTL and testbench

Per-channel sensor polling engine inside TheFFM, directly downstream of a UART byte receiver and upstream of the telemetry buffer that feeds the Orbita serializer.
- On a measurement start, drives the sensor request line (UARTx_dRX) with a pulse.
- Parses the 15-byte reply as 3 frames of 5 bytes, each a 0x55 sync byte followed by 4 data bytes.
- Writes the 12 data bytes to the buffer and reports done, sync error or timeout.

---
 rtl/sensor_poll_rx.sv | 147 ++++++++++++++
 tb/tb_sensor_poll_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_poll_rx.sv
// Sensor polling engine: pulses the request line, parses a framed UART reply
// into buffer writes, and reports done / sync error / timeout.
module sensor_poll_rx #(
  parameter int         REQ_LEN   = 16,
  parameter int         TIMEOUT   = 16000,
  parameter logic [7:0] SYNC      = 8'h55,
  parameter int         FRAMES    = 3,
  parameter int         FRAME_LEN = 5,
  parameter int         ADDR_W    = 4
) (
  input  logic              clk80,
  input  logic              rst_n,
  input  logic              iStart,
  input  logic              iRxValid,
  input  logic [7:0]        iRxData,
  output logic              oReq,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [7:0]        oWrData,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErrSync,
  output logic              oErrTimeout
);
  localparam int NB = FRAMES * FRAME_LEN;
  localparam int PW = $clog2(NB);
  localparam int SW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RECV} state_t;
  state_t state, state_nxt;

  logic [7:0]        req_cnt;
  logic [PW-1:0]     pos;
  logic [SW-1:0]     sub;
  logic [ADDR_W-1:0] waddr;
  logic [TW-1:0]     tcnt;

  logic              req_d, busy_d, wr_en_d, done_d, esync_d, eto_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_data_d;

  logic pulse, req_end, at_sync, at_last, sync_bad, byte_end, t_hit;

  // A start coinciding with a completion pulse is dropped, not queued.
  assign pulse    = oDone | oErrSync | oErrTimeout;
  assign req_end  = (req_cnt == 8'(REQ_LEN - 1));
  assign at_sync  = (sub == '0);
  assign at_last  = (pos == PW'(NB - 1));
  assign sync_bad = iRxValid && at_sync && (iRxData != SYNC);
  assign byte_end = sync_bad || (iRxValid && !at_sync && at_last);
  assign t_hit    = (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iStart && !pulse) state_nxt = REQ;
      REQ:     if (req_end) state_nxt = RECV;
      RECV:    if (byte_end || t_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte events take priority over the timeout landing on the same cycle.
  always_comb begin
    req_d     = (state_nxt == REQ);
    busy_d    = (state_nxt != IDLE);
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    done_d    = 1'b0;
    esync_d   = 1'b0;
    eto_d     = 1'b0;
    if (state == RECV) begin
      if (iRxValid && !at_sync) begin
        wr_en_d   = 1'b1;
        wr_addr_d = waddr;
        wr_data_d = iRxData;
        done_d    = at_last;
      end
      esync_d = sync_bad;
      eto_d   = t_hit && !byte_end;
    end
  end

  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) begin
      oReq        <= 1'b0;
      oBusy       <= 1'b0;
      oWrEn       <= 1'b0;
      oWrAddr     <= '0;
      oWrData     <= '0;
      oDone       <= 1'b0;
      oErrSync    <= 1'b0;
      oErrTimeout <= 1'b0;
    end else begin
      oReq        <= req_d;
      oBusy       <= busy_d;
      oWrEn       <= wr_en_d;
      oWrAddr     <= wr_addr_d;
      oWrData     <= wr_data_d;
      oDone       <= done_d;
      oErrSync    <= esync_d;
      oErrTimeout <= eto_d;
    end
  end

  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt <= '0;
      pos     <= '0;
      sub     <= '0;
      waddr   <= '0;
      tcnt    <= '0;
    end else begin
      case (state)
        REQ: begin
          req_cnt <= req_cnt + 8'd1;
          pos     <= '0;
          sub     <= '0;
          waddr   <= '0;
          tcnt    <= '0;
        end
        RECV: begin
          if (tcnt != TW'(TIMEOUT)) tcnt <= tcnt + TW'(1);
          if (iRxValid && !sync_bad) begin
            pos <= pos + PW'(1);
            sub <= (sub == SW'(FRAME_LEN - 1)) ? '0 : sub + SW'(1);
            if (!at_sync) waddr <= waddr + ADDR_W'(1);
          end
        end
        default: begin
          req_cnt <= '0;
          pos     <= '0;
          sub     <= '0;
          waddr   <= '0;
          tcnt    <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sensor_poll_rx.sv
// Bench for sensor_poll_rx: scenario table, corner sequences and random packets
// checked against a packet-level reference model.
module tb_sensor_poll_rx;
  localparam int         RL = 16;
  localparam int         TO = 3000;
  localparam int         FL = 5;
  localparam int         NB = 15;
  localparam logic [7:0] SY = 8'h55;
  localparam int K_NONE = 0, K_DONE = 1, K_SYNC = 2, K_TO = 3;

  logic       clk80 = 1'b0, rst_n = 1'b1, iStart = 1'b0, iRxValid = 1'b0;
  logic [7:0] iRxData = 8'h00;
  logic       oReq, oWrEn, oBusy, oDone, oErrSync, oErrTimeout;
  logic [3:0] oWrAddr;
  logic [7:0] oWrData;

  always #6 clk80 = ~clk80;

  sensor_poll_rx #(.REQ_LEN(RL), .TIMEOUT(TO)) dut (
    .clk80(clk80), .rst_n(rst_n), .iStart(iStart), .iRxValid(iRxValid),
    .iRxData(iRxData), .oReq(oReq), .oWrEn(oWrEn), .oWrAddr(oWrAddr),
    .oWrData(oWrData), .oBusy(oBusy), .oDone(oDone), .oErrSync(oErrSync),
    .oErrTimeout(oErrTimeout)
  );

  typedef struct {int c; logic [7:0] b;} strobe_t;
  typedef struct {int c; int a; int d;} wr_t;
  typedef struct {string nm; int n; int gap; int bad; logic [7:0] badv; int kind; int nw;} vec_t;

  strobe_t stim[$];
  int      xstart[$];
  wr_t     exp_w[$];
  wr_t     obs_w[$];
  vec_t    tbl[7];
  int      nerr = 0, nchk = 0;

  function automatic int outs();
    return int'({oReq, oWrEn, oWrAddr, oWrData, oBusy, oDone, oErrSync, oErrTimeout});
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic build(input int n, input int first, input int gap, input int bad,
                       input logic [7:0] badv, input logic [7:0] dbase);
    stim.delete();
    xstart.delete();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      if (i % FL == 0) b = (i == bad) ? badv : SY;
      else             b = dbase + 8'(i - i / FL - 1);
      stim.push_back('{first + i * gap, b});
    end
  endtask

  // Reply bytes count from the first cycle after the request pulse, until
  // TIMEOUT cycles have passed; every fifth byte must be the sync byte.
  task automatic model(output int kind, output int endc);
    int f, dl, pos;
    f = 1 + RL;
    dl = f + TO - 1;
    pos = 0;
    exp_w.delete();
    kind = K_TO;
    endc = f + TO;
    foreach (stim[i]) begin
      if (stim[i].c < f) continue;
      if (stim[i].c > dl) break;
      if (pos % FL == 0) begin
        if (stim[i].b != SY) begin
          kind = K_SYNC;
          endc = stim[i].c + 1;
          return;
        end
      end else begin
        exp_w.push_back('{stim[i].c + 1, pos - pos / FL - 1, int'(stim[i].b)});
        if (pos == NB - 1) begin
          kind = K_DONE;
          endc = stim[i].c + 1;
          return;
        end
      end
      pos++;
    end
  endtask

  // Entered and left just after a rising edge; start is driven at relative cycle 0.
  task automatic run_txn(input string nm, input int want_kind, input int want_nw, input bit start_at_end);
    int kind, endc, span, si, okind, oend, npulse, rfirst, rcnt, bcnt;
    model(kind, endc);
    span = endc;
    foreach (stim[i]) if (stim[i].c > span) span = stim[i].c;
    if (start_at_end && span < endc + 2) span = endc + 2;
    obs_w.delete();
    okind = K_NONE; oend = -1; npulse = 0; rfirst = -1; rcnt = 0; bcnt = 0; si = 0;
    for (int r = 0; r <= span; r++) begin
      iStart = (r == 0) || (start_at_end && r == endc);
      foreach (xstart[k]) if (xstart[k] == r) iStart = 1'b1;
      iRxValid = 1'b0;
      iRxData  = 8'($urandom);
      if (si < stim.size() && stim[si].c == r) begin
        iRxValid = 1'b1;
        iRxData  = stim[si].b;
        si++;
      end
      @(negedge clk80);
      if (oWrEn) obs_w.push_back('{r, int'(oWrAddr), int'(oWrData)});
      if (oDone || oErrSync || oErrTimeout) begin
        npulse += int'(oDone) + int'(oErrSync) + int'(oErrTimeout);
        okind = oDone ? K_DONE : (oErrSync ? K_SYNC : K_TO);
        oend = r;
      end
      if (oReq) begin
        if (rcnt == 0) rfirst = r;
        rcnt++;
      end
      if (oBusy) bcnt++;
      @(posedge clk80);
      #1;
    end
    iStart = 1'b0;
    iRxValid = 1'b0;
    chk($sformatf("%s.kind", nm), okind, kind);
    chk($sformatf("%s.end_cycle", nm), oend, endc);
    chk($sformatf("%s.pulses", nm), npulse, 1);
    if (want_kind >= 0) chk($sformatf("%s.table_kind", nm), okind, want_kind);
    if (want_nw >= 0) chk($sformatf("%s.table_writes", nm), obs_w.size(), want_nw);
    chk($sformatf("%s.writes", nm), obs_w.size(), exp_w.size());
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
      chk($sformatf("%s.w%0d_cycle", nm, i), obs_w[i].c, exp_w[i].c);
      chk($sformatf("%s.w%0d_addr", nm, i), obs_w[i].a, exp_w[i].a);
      chk($sformatf("%s.w%0d_data", nm, i), obs_w[i].d, exp_w[i].d);
    end
    chk($sformatf("%s.req_first", nm), rfirst, 1);
    chk($sformatf("%s.req_len", nm), rcnt, RL);
    chk($sformatf("%s.busy_cycles", nm), bcnt, endc - 1);
  endtask

  task automatic run_idle(input int n);
    int acc;
    acc = 0;
    for (int r = 0; r < n; r++) begin
      iStart   = 1'b0;
      iRxValid = ($urandom_range(0, 1) == 1);
      iRxData  = ($urandom_range(0, 3) == 0) ? SY : 8'($urandom);
      @(negedge clk80);
      acc |= outs();
      @(posedge clk80);
      #1;
    end
    iRxValid = 1'b0;
    chk("idle_stray.outputs", acc, 0);
  endtask

  initial begin
    #(12 * 200000);
    $display("FAIL watchdog: got timeout expected completion");
    nerr++;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    strobe_t s;
    tbl[0] = '{"nominal",  15, 160, -1, 8'h00, K_DONE, 12};
    tbl[1] = '{"sync6",    15, 20,   5, 8'h54, K_SYNC, 4};
    tbl[2] = '{"timeout",  0,  1,   -1, 8'h00, K_TO,   0};
    tbl[3] = '{"partial7", 7,  20,  -1, 8'h00, K_TO,   5};
    tbl[4] = '{"sync1",    15, 3,    0, 8'hD5, K_SYNC, 0};
    tbl[5] = '{"sync11",   15, 7,   10, 8'h00, K_SYNC, 8};
    tbl[6] = '{"fast",     15, 1,   -1, 8'h00, K_DONE, 12};

    #2 rst_n = 1'b0;
    #2 chk("reset.outputs", outs(), 0);
    repeat (3) @(posedge clk80);
    @(negedge clk80) rst_n = 1'b1;
    @(posedge clk80);
    #1;

    for (int i = 0; i < 7; i++) begin
      build(tbl[i].n, 19, tbl[i].gap, tbl[i].bad, tbl[i].badv, 8'h91);
      run_txn(tbl[i].nm, tbl[i].kind, tbl[i].nw, 1'b0);
    end

    // Last byte exactly on the timeout cycle wins; one cycle later it is lost.
    build(15, 19, 1, -1, 8'h00, 8'h30);
    s = stim[14]; s.c = 16 + TO; stim[14] = s;
    run_txn("race_hit", K_DONE, 12, 1'b0);
    build(15, 19, 1, -1, 8'h00, 8'h30);
    s = stim[14]; s.c = 17 + TO; stim[14] = s;
    run_txn("race_late", K_TO, 11, 1'b0);

    // Restarts during REQ/RECV and on the done cycle, strays before the reply window.
    build(15, 19, 10, -1, 8'h00, 8'hA0);
    xstart = '{5, 40, 100};
    stim.push_front('{5, SY});
    stim.push_front('{0, SY});
    run_txn("midstart", K_DONE, 12, 1'b1);

    run_idle(50);

    for (int t = 0; t < 24; t++) begin
      int n, c, bad;
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 17)
                                      : (($urandom_range(0, 3) == 0) ? 17 : 15);
      bad = ($urandom_range(0, 4) == 0) ? 5 * $urandom_range(0, 2) : -1;
      c = $urandom_range(15, 30);
      stim.delete();
      xstart.delete();
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        if (i % FL == 0 && i != bad) b = SY;
        else if (i % FL == 0) begin
          b = 8'($urandom);
          if (b == SY) b = 8'h00;
        end else b = 8'($urandom);
        stim.push_back('{c, b});
        c += $urandom_range(1, 12);
      end
      run_txn($sformatf("rnd%0d", t), -1, -1, 1'b0);
    end

    // Reset in the middle of a reply aborts silently.
    build(15, 19, 4, -1, 8'h00, 8'h10);
    for (int r = 0; r <= stim[7].c + 1; r++) begin
      iStart = (r == 0);
      iRxValid = 1'b0;
      foreach (stim[k]) if (stim[k].c == r) begin
        iRxValid = 1'b1;
        iRxData = stim[k].b;
      end
      @(posedge clk80);
      #1;
    end
    iStart = 1'b0;
    iRxValid = 1'b0;
    chk("rst_mid.busy_before", int'(oBusy), 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid.outputs_now", outs(), 0);
    @(posedge clk80);
    #1 chk("rst_mid.outputs_held", outs(), 0);
    @(negedge clk80) rst_n = 1'b1;
    @(posedge clk80);
    @(negedge clk80) chk("rst_mid.no_pulse_after", outs(), 0);
    @(posedge clk80);
    #1;
    build(15, 19, 20, -1, 8'h00, 8'h91);
    run_txn("post_rst", K_DONE, 12, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
